// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, tracking the PC and retired-instruction count.
module multicycle_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic [31:0] alu_result,
  input  logic        branch,
  input  logic [31:0] imm32,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [31:0] alu_q,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [15:0] pc,
  output logic [31:0] instret,
  output logic        halt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC4 = 2'b10;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, next_pc;
  logic [31:0] ir_q, ir_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  logic [6:0]  opcode;
  logic        legal_op;

  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic [1:0]  rf_wsel_q, rf_wsel_d;
  logic        halt_q, halt_d;

  // Only the low PC-width bits of the immediate take part in PC arithmetic.
  logic        unused_imm_hi;
  assign unused_imm_hi = ^imm32[31:16];

  assign opcode = ir_q[6:0];

  always_comb begin
    unique case (opcode)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_res_d = alu_res_q;
    instret_d = instret_q;
    retire    = 1'b0;
    next_pc   = pc_q + 16'd4;

    unique case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_HALT;
        end else if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal_op ? S_EXEC : S_HALT;
      S_EXEC: begin
        alu_res_d = alu_result;
        unique case (opcode)
          OP_BRANCH: begin
            retire  = 1'b1;
            state_d = S_FETCH;
            if (branch) next_pc = pc_q + imm32[15:0];
          end
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          if (opcode == OP_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
        if (opcode == OP_JAL)       next_pc = pc_q + imm32[15:0];
        else if (opcode == OP_JALR) next_pc = alu_res_q[15:0];
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    if (retire) begin
      pc_d      = next_pc;
      instret_d = instret_q + 32'd1;
    end
  end

  // Outputs are registered from the next state so they change only on clock
  // edges and drop asynchronously with reset.
  always_comb begin
    imem_req_d = (state_d == S_FETCH) && (pc_d[1:0] == 2'b00);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && (opcode == OP_STORE);
    rf_we_d    = (state_d == S_WB);
    halt_d     = (state_d == S_HALT);
    rf_wsel_d  = WSEL_ALU;
    if (state_d == S_WB) begin
      if (opcode == OP_LOAD)                          rf_wsel_d = WSEL_MEM;
      else if (opcode == OP_JAL || opcode == OP_JALR) rf_wsel_d = WSEL_PC4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= IR_NOP;
      alu_res_q  <= '0;
      instret_q  <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wsel_q  <= WSEL_ALU;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      alu_res_q  <= alu_res_d;
      instret_q  <= instret_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      rf_wsel_q  <= rf_wsel_d;
      halt_q     <= halt_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign alu_q     = alu_res_q;
  assign rf_we     = rf_we_q;
  assign rf_wsel   = rf_wsel_q;
  assign pc        = pc_q;
  assign instret   = instret_q;
  assign halt      = halt_q;

endmodule
